logic_reducer: RTL and testbench
================================

LOGIC_REDUCER -- requirements
Module: logic_reducer

Interface
REQ-001 Parameter WIDTH, default 4, operand/result bit width (>=1).
REQ-002 Parameter COUNT, default 3, operands per reduction (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous abort of current reduction.
REQ-006 op  input  2  reduction mode: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 in_valid  input  1  operand a present.
REQ-008 in_ready  output  1  block accepts operand this cycle.
REQ-009 a  input  WIDTH  operand.
REQ-010 out_valid  output  1  result s valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 s  output  WIDTH  reduction result.
REQ-013 busy  output  1  reduction in progress (state ACC).

Function
REQ-014 States SHALL be IDLE, ACC, DONE; state, accumulator, operand counter and latched op SHALL be registers.
REQ-015 Operand accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, 0 in DONE.
REQ-017 IDLE + accept: accumulator <= a, op latched, counter <= 1, next state ACC.
REQ-018 ACC + accept: accumulator <= acc AND/OR/XOR a per latched op (NAND accumulates as AND), counter +1.
REQ-019 ACC accept making counter equal COUNT SHALL move to DONE; out_valid SHALL rise the cycle after that accept (latency 1 cycle from last operand).
REQ-020 op changes after the first accept SHALL be ignored until the next reduction.
REQ-021 s SHALL equal accumulator, bitwise inverted when latched op=11; s SHALL hold stable while out_valid=1.
REQ-022 out_valid SHALL be 1 only in DONE; DONE + out_ready=1 SHALL return to IDLE next edge, out_valid 0.
REQ-023 DONE with out_ready=0 SHALL hold result indefinitely; in_valid ignored.
REQ-024 in_valid=0 in ACC SHALL leave accumulator and counter unchanged (gaps allowed).
REQ-025 clr=1 SHALL force IDLE next edge from any state, counter 0, accumulator 0, discarding any pending result; clr SHALL take priority over a simultaneous accept or out_ready.
REQ-026 Counter SHALL be ceil(log2(COUNT+1)) bits wide and never exceed COUNT.
REQ-027 busy SHALL be 1 only in ACC.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, set state IDLE, accumulator 0, counter 0, latched op 00.
REQ-029 During and after reset until first accept: in_ready=1, out_valid=0, busy=0, s=0.
REQ-030 rst asserted mid-reduction or in DONE SHALL discard all partial/complete results; first accept after release starts a fresh reduction.

Verification (WIDTH=4, COUNT=3)
REQ-031 op=00, operands 1111,1011,1001 back-to-back, out_ready=1 -> out_valid one cycle after third accept, s=1001, one cycle, then IDLE.
REQ-032 op=11, operands 1111,1111,0111 -> s=1000; op=10, operands 1100,1010,0001 -> s=0111.
REQ-033 op=01, operands 0001,0000,0100 with in_valid gaps and op toggled to 00 after first accept -> s=0101, busy=1 throughout ACC.
REQ-034 Result ready with out_ready=0 for 5 cycles -> out_valid and s stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 clr=1 coincident with second accept -> IDLE, next three operands 0110,0111,1110 op=00 -> s=0110, unaffected by aborted data.
REQ-036 rst pulse asserted between clock edges during ACC -> outputs at reset values before next edge; subsequent full reduction correct.

Source files
------------

// File: rtl/logic_reducer.sv
// Streaming bitwise reducer: folds COUNT operands with AND/OR/XOR/NAND and
// presents the result on a valid/ready handshake.
module logic_reducer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  localparam int unsigned CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             accept;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] acc_fold;

  // Outputs decode straight from registered state, so reset takes effect
  // on them immediately without waiting for a clock edge.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACC);
  assign s         = (op_q == 2'b11) ? ~acc_q : acc_q;

  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + CW'(1);

  // NAND folds as AND; the inversion is applied only on the output.
  always_comb begin
    acc_fold = acc_q & a;
    case (op_q)
      2'b01:   acc_fold = acc_q | a;
      2'b10:   acc_fold = acc_q ^ a;
      default: acc_fold = acc_q & a;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = a;
            op_d    = op;
            cnt_d   = CW'(1);
            state_d = ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = acc_fold;
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(COUNT)) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_logic_reducer.sv
// Bench for logic_reducer: directed stimulus pushes expected results into a
// queue; a negedge monitor pops and compares on every output handshake.
module tb_logic_reducer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned COUNT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  logic_reducer #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Result checking on each handshake, decoupled from the stimulus.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(s), 32'hFFFF_FFFF);
      end else begin
        chk("result_s", 32'(s), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until accepted; in_valid stays high.
  task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] v);
    op       = o;
    a        = v;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; op = 2'b00; in_valid = 1'b0; a = '0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // AND back-to-back, one-cycle latency then back to IDLE
    exp_q.push_back(4'b1001);
    send(2'b00, 4'b1111);
    chk("and_busy", 32'(busy), 32'd1);
    send(2'b00, 4'b1011);
    send(2'b00, 4'b1001);
    chk("and_out_valid", 32'(out_valid), 32'd1);
    chk("and_in_ready_done", 32'(in_ready), 32'd0);
    idle();
    step();
    chk("and_out_valid_drop", 32'(out_valid), 32'd0);
    chk("and_idle_ready", 32'(in_ready), 32'd1);

    // NAND then XOR
    exp_q.push_back(4'b1000);
    send(2'b11, 4'b1111); send(2'b11, 4'b1111); send(2'b11, 4'b0111);
    exp_q.push_back(4'b0111);
    send(2'b10, 4'b1100); send(2'b10, 4'b1010); send(2'b10, 4'b0001);
    idle();
    step();

    // OR with gaps, op toggled after first accept
    exp_q.push_back(4'b0101);
    send(2'b01, 4'b0001);
    idle(); op = 2'b00;
    step();
    chk("gap_busy1", 32'(busy), 32'd1);
    send(2'b00, 4'b0000);
    idle();
    step(); step();
    chk("gap_busy2", 32'(busy), 32'd1);
    send(2'b00, 4'b0100);
    idle();
    step();

    // Back-pressure: result held 5 cycles, extra operands ignored
    out_ready = 1'b0;
    exp_q.push_back(4'b0110);
    send(2'b00, 4'b1110); send(2'b00, 4'b0111); send(2'b00, 4'b1111);
    a = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_s", 32'(s), 32'h6);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    idle();
    out_ready = 1'b1;
    step();
    chk("hold_release", 32'(out_valid), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);

    // clr coincident with second accept
    send(2'b00, 4'b1111);
    a = 4'b0000; clr = 1'b1;
    step();
    clr = 1'b0; idle();
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_s", 32'(s), 32'd0);
    exp_q.push_back(4'b0110);
    send(2'b00, 4'b0110); send(2'b00, 4'b0111); send(2'b00, 4'b1110);
    idle();
    step();

    // Async reset mid-ACC
    send(2'b10, 4'b0011); send(2'b10, 4'b0101);
    idle();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_s", 32'(s), 32'd0);
    step();
    rst = 1'b0;
    step();
    exp_q.push_back(4'b1011);
    send(2'b01, 4'b1000); send(2'b01, 4'b0001); send(2'b01, 4'b0010);
    idle();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got %0t expected done", $time);
    $fatal(1, "timeout");
  end

endmodule
